universal_shift_seq: RTL and testbench

//  Parametrised universal shift register (WIDTH bits): hold, serial shift, parallel load,

---
 rtl/universal_shift_pkg.sv | 30 +++
 rtl/universal_shift_step.sv | 31 +++
 rtl/universal_shift_seq.sv | 90 +++++++++
 tb/tb_universal_shift_seq.sv | 197 +++++++++++++++++++
 4 files changed

// File: rtl/universal_shift_pkg.sv
// Purpose: shared mode codes, sequencer states and helpers for the universal shifter.
// Latency: n/a (types and functions only).
// Backpressure: n/a.
package universal_shift_pkg;

  // Operation codes; 0-3 keep the legacy 4-bit universal shifter encoding
  typedef enum logic [2:0] {
    MODE_HOLD = 3'd0,
    MODE_SHR  = 3'd1,
    MODE_SHL  = 3'd2,
    MODE_LOAD = 3'd3,
    MODE_ROR  = 3'd4,
    MODE_ROL  = 3'd5,
    MODE_ASR  = 3'd6,
    MODE_RSVD = 3'd7
  } mode_e;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_DONE  = 2'd2
  } state_e;

  // True for modes that actually move data when repeated; hold, load and
  // reserved finish immediately when started as a sequence.
  function automatic logic is_seq_mode(input logic [2:0] m);
    return !((m == MODE_HOLD) || (m == MODE_LOAD) || (m == MODE_RSVD));
  endfunction

endpackage

// File: rtl/universal_shift_step.sv
// Purpose: combinational next value of the shift register for one operation.
// Latency: 0 cycles (pure combinational).
// Backpressure: none; the caller decides whether to register the result.
module universal_shift_step
  import universal_shift_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic [WIDTH-1:0] cur,
  input  logic [2:0]       mode,
  input  logic [WIDTH-1:0] par_in,
  input  logic             sr_in,
  input  logic             sl_in,
  output logic [WIDTH-1:0] nxt
);

  // Select one step of the requested operation; reserved code behaves as hold
  always_comb begin
    nxt = cur;
    case (mode)
      MODE_SHR:  nxt = {sr_in, cur[WIDTH-1:1]};
      MODE_SHL:  nxt = {cur[WIDTH-2:0], sl_in};
      MODE_LOAD: nxt = par_in;
      MODE_ROR:  nxt = {cur[0], cur[WIDTH-1:1]};
      MODE_ROL:  nxt = {cur[WIDTH-2:0], cur[WIDTH-1]};
      MODE_ASR:  nxt = {cur[WIDTH-1], cur[WIDTH-1:1]};
      default:   nxt = cur;
    endcase
  end

endmodule

// File: rtl/universal_shift_seq.sv
// Purpose: universal shift register with an N-step shift/rotate sequencer (busy/done).
// Latency: single ops 1 cycle; a sequence is 1 start cycle + amount steps + 1 done cycle.
// Backpressure: en=0 freezes register, counter and FSM everywhere except DONE.
module universal_shift_seq
  import universal_shift_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int AMT_W = $clog2(WIDTH + 1)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             en,
  input  logic [2:0]       mode,
  input  logic [WIDTH-1:0] par_in,
  input  logic             sr_in,
  input  logic             sl_in,
  input  logic             start,
  input  logic [AMT_W-1:0] amount,
  output logic [WIDTH-1:0] out,
  output logic             sr_out,
  output logic             sl_out,
  output logic             busy,
  output logic             done
);

  state_e           state;
  logic [2:0]       seq_mode;
  logic [AMT_W-1:0] cnt;
  logic [2:0]       step_mode;
  logic [WIDTH-1:0] step_nxt;

  // While sequencing, the latched mode drives the step logic; live mode is ignored
  assign step_mode = (state == ST_SHIFT) ? seq_mode : mode;

  universal_shift_step #(
    .WIDTH (WIDTH)
  ) u_step (
    .cur    (out),
    .mode   (step_mode),
    .par_in (par_in),
    .sr_in  (sr_in),
    .sl_in  (sl_in),
    .nxt    (step_nxt)
  );

  // FSM, step counter, mode latch and data register
  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= ST_IDLE;
      out      <= '0;
      cnt      <= '0;
      seq_mode <= MODE_HOLD;
    end else begin
      case (state)
        ST_IDLE: begin
          if (en) begin
            if (start) begin
              seq_mode <= mode;
              cnt      <= amount;
              if ((amount == '0) || !is_seq_mode(mode)) state <= ST_DONE;
              else                                      state <= ST_SHIFT;
            end else begin
              out <= step_nxt;
            end
          end
        end
        ST_SHIFT: begin
          if (en) begin
            out <= step_nxt;
            cnt <= cnt - AMT_W'(1);
            if (cnt == AMT_W'(1)) state <= ST_DONE;
          end
        end
        ST_DONE: begin
          state <= ST_IDLE;
        end
        default: begin
          state <= ST_IDLE;
        end
      endcase
    end
  end

  // Status and serial outputs decoded straight from registers
  assign busy   = (state == ST_SHIFT);
  assign done   = (state == ST_DONE);
  assign sr_out = out[0];
  assign sl_out = out[WIDTH-1];

endmodule

// File: tb/tb_universal_shift_seq.sv
module tb_universal_shift_seq;
  localparam int W  = 8;
  localparam int AW = 4;

  logic          clk = 1'b0;
  logic          reset, en, start, sr_in, sl_in;
  logic [2:0]    mode;
  logic [W-1:0]  par_in;
  logic [AW-1:0] amount;
  logic [W-1:0]  out;
  logic          sr_out, sl_out, busy, done;

  universal_shift_seq #(.WIDTH(W), .AMT_W(AW)) dut (
    .clk(clk), .reset(reset), .en(en), .mode(mode), .par_in(par_in),
    .sr_in(sr_in), .sl_in(sl_in), .start(start), .amount(amount),
    .out(out), .sr_out(sr_out), .sl_out(sl_out), .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic         en;
    logic [2:0]   mode;
    logic [W-1:0] par;
    logic         sr;
    logic         sl;
    logic [W-1:0] exp;
  } vec_t;

  vec_t         tv[15];
  logic [W-1:0] exp_q[$];
  int           checks = 0;
  int           errors = 0;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", nm, act, req);
    end
  endtask

  task automatic pop_chk(input string nm);
    if (exp_q.size() == 0) begin
      checks++;
      errors++;
      $display("FAIL %s scoreboard empty, actual=%0h", nm, out);
    end else begin
      chk(nm, {24'h0, out}, {24'h0, exp_q.pop_front()});
    end
  endtask

  task automatic load(input logic [W-1:0] v);
    mode = 3'd3; par_in = v; en = 1'b1; start = 1'b0;
    exp_q.push_back(v);
    tick();
    pop_chk("load");
    mode = 3'd0;
  endtask

  // Start a sequence, count busy cycles (optionally stalling 2 cycles), check result and done
  task automatic run_seq(input string nm, input logic [2:0] m, input logic [AW-1:0] amt,
                         input int stall_at, input int exp_busy, input logic [W-1:0] exp_out);
    int n;
    exp_q.push_back(exp_out);
    mode = m; amount = amt; start = 1'b1; en = 1'b1;
    tick();
    start  = 1'b0;
    mode   = 3'd3;              // must be ignored while busy
    par_in = W'($urandom);
    amount = AW'($urandom);
    n = 0;
    while (busy && n < 64) begin
      n++;
      if (n == stall_at) en = 1'b0;
      if (n == stall_at + 2) en = 1'b1;
      tick();
    end
    en = 1'b1;
    chk({nm, "_busy_cycles"}, n, exp_busy);
    chk({nm, "_done"}, done, 1'b1);
    pop_chk({nm, "_out"});
    mode = 3'd0;
    tick();
    chk({nm, "_done_clear"}, done, 1'b0);
    chk({nm, "_idle"}, busy, 1'b0);
    chk({nm, "_out_hold"}, out, exp_out);
  endtask

  initial begin
    // en, mode, par, sr, sl, expected out (starting from 0x00)
    tv[0]  = '{1'b1, 3'd3, 8'hA5, 1'b0, 1'b0, 8'hA5};
    tv[1]  = '{1'b1, 3'd1, 8'h00, 1'b1, 1'b0, 8'hD2};
    tv[2]  = '{1'b1, 3'd2, 8'h00, 1'b0, 1'b1, 8'hA5};
    tv[3]  = '{1'b1, 3'd4, 8'h00, 1'b0, 1'b0, 8'hD2};
    tv[4]  = '{1'b1, 3'd5, 8'h00, 1'b1, 1'b1, 8'hA5};
    tv[5]  = '{1'b1, 3'd6, 8'h00, 1'b0, 1'b0, 8'hD2};
    tv[6]  = '{1'b1, 3'd0, 8'hFF, 1'b1, 1'b1, 8'hD2};
    tv[7]  = '{1'b1, 3'd7, 8'hFF, 1'b1, 1'b1, 8'hD2};
    tv[8]  = '{1'b1, 3'd3, 8'h3C, 1'b0, 1'b0, 8'h3C};
    tv[9]  = '{1'b1, 3'd6, 8'h00, 1'b1, 1'b1, 8'h1E};
    tv[10] = '{1'b1, 3'd1, 8'h00, 1'b0, 1'b1, 8'h0F};
    tv[11] = '{1'b1, 3'd2, 8'h00, 1'b1, 1'b0, 8'h1E};
    tv[12] = '{1'b1, 3'd5, 8'h00, 1'b0, 1'b0, 8'h3C};
    tv[13] = '{1'b1, 3'd4, 8'h00, 1'b1, 1'b1, 8'h1E};
    tv[14] = '{1'b0, 3'd3, 8'hFF, 1'b1, 1'b1, 8'h1E};

    // Reset for two edges with random inputs
    reset = 1'b1;
    en = 1'($urandom); mode = 3'($urandom); par_in = W'($urandom);
    sr_in = 1'($urandom); sl_in = 1'($urandom); start = 1'b1; amount = AW'($urandom);
    tick();
    en = 1'($urandom); mode = 3'($urandom); par_in = W'($urandom);
    tick();
    chk("reset_out", out, 8'h00);
    chk("reset_busy", busy, 1'b0);
    chk("reset_done", done, 1'b0);
    reset = 1'b0; start = 1'b0; en = 1'b1; mode = 3'd0;
    sr_in = 1'b0; sl_in = 1'b0;

    // Single-cycle operations from the table
    for (int i = 0; i < 15; i++) begin
      en = tv[i].en; mode = tv[i].mode; par_in = tv[i].par;
      sr_in = tv[i].sr; sl_in = tv[i].sl;
      exp_q.push_back(tv[i].exp);
      tick();
      pop_chk($sformatf("vec%0d_out", i));
      chk($sformatf("vec%0d_sr_out", i), sr_out, tv[i].exp[0]);
      chk($sformatf("vec%0d_sl_out", i), sl_out, tv[i].exp[W-1]);
      chk($sformatf("vec%0d_busy", i), busy, 1'b0);
    end
    en = 1'b1; sr_in = 1'b0; sl_in = 1'b0;

    // ROL by 3 of 0x81
    load(8'h81);
    run_seq("rol3", 3'd5, 4'd3, 0, 3, 8'h0C);

    // ASR by 7 of 0x80 saturates to all ones, then amount 0 leaves data alone
    load(8'h80);
    run_seq("asr7", 3'd6, 4'd7, 0, 7, 8'hFF);
    run_seq("asr0", 3'd6, 4'd0, 0, 0, 8'hFF);

    // Load as a sequence completes at once without touching data
    par_in = 8'h12;
    run_seq("seqload", 3'd3, 4'd5, 0, 0, 8'hFF);

    // ROR by 4 with a two-cycle en stall in the middle
    load(8'h1B);
    run_seq("ror4_stall", 3'd4, 4'd4, 2, 6, 8'hB1);

    // Amount larger than the width: ROR by 9 equals ROR by 1
    load(8'h81);
    run_seq("ror9", 3'd4, 4'd9, 0, 9, 8'hC0);

    // SHL with serial input 1 through a full width
    load(8'h00);
    sl_in = 1'b1;
    run_seq("shl10_ones", 3'd2, 4'd10, 0, 10, 8'hFF);
    sl_in = 1'b0;

    // Reset in the middle of a sequence aborts without a done pulse
    load(8'h01);
    mode = 3'd2; amount = 4'd5; start = 1'b1;
    tick();
    start = 1'b0; mode = 3'd0;
    tick();
    tick();
    chk("abort_mid_out", out, 8'h04);
    chk("abort_mid_busy", busy, 1'b1);
    reset = 1'b1;
    tick();
    chk("abort_out", out, 8'h00);
    chk("abort_busy", busy, 1'b0);
    chk("abort_done", done, 1'b0);
    reset = 1'b0;
    tick();
    chk("abort_no_done", done, 1'b0);
    chk("abort_idle", busy, 1'b0);

    chk("scoreboard_drained", exp_q.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  // Global time limit so the bench always ends
  initial begin
    #200000;
    $display("FAIL timeout actual=running required=finished");
    $fatal(1, "timeout");
  end

endmodule
